// File: rtl/shared_bus_pkg.sv
// -----------------------------------------------------------------------------
// shared_bus_pkg
// Shared types and default sizes for the shared bus controller.
//   snoop_t     : 2-bit snoop bus encoding seen on snoop_in_i / result_o
//   bus_state_t : transaction sequencer states
// -----------------------------------------------------------------------------
package shared_bus_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned OP_W            = 8;
    localparam int unsigned DEF_SNOOP_LAT   = 2;
    localparam int unsigned DEF_STALL_LIMIT = 15;

    typedef enum logic [1:0] {
        SNOOP_MISS  = 2'b00,
        SNOOP_HIT   = 2'b01,
        SNOOP_HITM  = 2'b10,
        SNOOP_STALL = 2'b11
    } snoop_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_SNOOP = 3'd2,
        ST_WB    = 3'd3,
        ST_MEM   = 3'd4,
        ST_DONE  = 3'd5
    } bus_state_t;

endpackage

// File: rtl/shared_bus_controller_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first active request found when
// scanning upward from ptr_i (wrapping) wins.
//   req_i  : request levels
//   ptr_i  : index holding highest priority this round
//   pick_o : one-hot winner, all zero when no request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         pick_o
);

    logic        found_s;
    logic [31:0] idx_s;

    // Scan from the pointer; found_s masks every request after the first hit.
    always_comb begin
        pick_o  = '0;
        found_s = 1'b0;
        idx_s   = 32'd0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx_s   = (32'(ptr_i) + 32'(k)) % 32'(NUM_REQ);
            pick_o[idx_s[$clog2(NUM_REQ)-1:0]] = req_i[idx_s[$clog2(NUM_REQ)-1:0]] & ~found_s;
            found_s = found_s | req_i[idx_s[$clog2(NUM_REQ)-1:0]];
        end
    end

endmodule

// File: rtl/shared_bus_controller.sv
// -----------------------------------------------------------------------------
// shared_bus_controller
// Arbitrates the shared L2 bus among NUM_REQ requesters and sequences each
// transaction through ADDR -> SNOOP -> (WB) -> MEM -> DONE.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req_i           : per-requester request level
//   req_op_i        : per-requester 8-bit op, slice i = [8i+7:8i]
//   req_addr_i      : per-requester address, slice i = [ADDR_W*i +: ADDR_W]
//   gnt_o           : one-hot grant held for the whole transaction
//   done_o          : one-cycle completion pulse to the winner
//   result_o        : sampled snoop result, valid with done_o
//   bus_valid_o     : one-cycle address phase strobe
//   bus_op_o/addr_o : latched op/address, held ADDR..DONE, zero in IDLE
//   snoop_in_i      : 00 MISS, 01 HIT, 10 HITM, 11 STALL
//   hitm_wb_o       : snooper writeback phase active
//   mem_rdy_i       : memory completes current WB/MEM phase
//   timeout_err_o   : sticky snoop timeout flag
// Build option: define SHARED_BUS_SNOOP_TIMEOUT_EN to abort a transaction
// after STALL_LIMIT consecutive stall samples; otherwise stalls wait forever
// and timeout_err_o is tied low.
// -----------------------------------------------------------------------------
import shared_bus_pkg::*;

module shared_bus_controller #(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned SNOOP_LAT   = DEF_SNOOP_LAT,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [1:0]                result_o,
    output logic                      bus_valid_o,
    output logic [OP_W-1:0]           bus_op_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    input  logic [1:0]                snoop_in_i,
    output logic                      hitm_wb_o,
    input  logic                      mem_rdy_i,
    output logic                      timeout_err_o
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    // One width serves both the snoop-latency and the stall counter.
    localparam int unsigned CNT_MAX = (SNOOP_LAT > STALL_LIMIT) ? SNOOP_LAT : STALL_LIMIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    bus_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    snoop_t              snoop_q, snoop_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    snoop_t              result_q, result_d;
    logic                bus_valid_q, bus_valid_d;
    logic                hitm_wb_q, hitm_wb_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [NUM_REQ-1:0]  pick_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [PTR_W-1:0]    next_ptr_s;
    logic [OP_W-1:0]     op_sel_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    snoop_t              snoop_s;

`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                timeout_q, timeout_d;
`endif

    assign snoop_s = snoop_t'(snoop_in_i);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (pick_s)
    );

    // Mux the winner's op/address and find its index (pick_s is one-hot).
    always_comb begin
        op_sel_s   = '0;
        addr_sel_s = '0;
        win_idx_s  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            op_sel_s   = op_sel_s   | (req_op_i[OP_W*i +: OP_W]       & {OP_W{pick_s[i]}});
            addr_sel_s = addr_sel_s | (req_addr_i[ADDR_W*i +: ADDR_W] & {ADDR_W{pick_s[i]}});
            win_idx_s  = win_idx_s  | (PTR_W'(i) & {PTR_W{pick_s[i]}});
        end
        next_ptr_s = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
    end

    // Next-state logic; output registers are decoded from the next state so
    // every output is a flop.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        snoop_d  = snoop_q;
        gnt_d    = gnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_ADDR;
                    gnt_d   = pick_s;
                    op_d    = op_sel_s;
                    addr_d  = addr_sel_s;
                    ptr_d   = next_ptr_s;
                    snoop_d = SNOOP_MISS;
                end else begin
                    gnt_d  = '0;
                    op_d   = '0;
                    addr_d = '0;
                end
            end
            ST_ADDR: begin
                cnt_d   = CNT_W'(SNOOP_LAT);
                state_d = ST_SNOOP;
`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
                stall_d = '0;
`endif
            end
            ST_SNOOP: begin
                // The counter parks at 1 so every later stall cycle resamples.
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (snoop_s)
                        SNOOP_STALL: begin
`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
                            if (stall_q == CNT_W'(STALL_LIMIT - 1)) begin
                                state_d   = ST_DONE;
                                snoop_d   = SNOOP_MISS;
                                timeout_d = 1'b1;
                            end else begin
                                stall_d = stall_q + CNT_W'(1);
                            end
`else
                            state_d = ST_SNOOP;
`endif
                        end
                        SNOOP_HITM: begin
                            snoop_d = SNOOP_HITM;
                            state_d = ST_WB;
                        end
                        default: begin
                            snoop_d = snoop_s;
                            state_d = ST_MEM;
                        end
                    endcase
                end
            end
            ST_WB: begin
                if (mem_rdy_i) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_rdy_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                op_d    = '0;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                op_d    = '0;
                addr_d  = '0;
            end
        endcase

        bus_valid_d = (state_d == ST_ADDR);
        hitm_wb_d   = (state_d == ST_WB);
        done_d      = (state_d == ST_DONE) ? gnt_d : '0;
        result_d    = (state_d == ST_DONE) ? snoop_d : SNOOP_MISS;
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            snoop_q     <= SNOOP_MISS;
            gnt_q       <= '0;
            done_q      <= '0;
            result_q    <= SNOOP_MISS;
            bus_valid_q <= 1'b0;
            hitm_wb_q   <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            snoop_q     <= snoop_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            bus_valid_q <= bus_valid_d;
            hitm_wb_q   <= hitm_wb_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
        end
    end

`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
    // Stall counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_err_o = timeout_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign bus_valid_o = bus_valid_q;
    assign bus_op_o    = op_q;
    assign bus_addr_o  = addr_q;
    assign hitm_wb_o   = hitm_wb_q;

endmodule

// File: tb/tb_shared_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_shared_bus_controller
// Scoreboard bench: each transaction's expected winner/op/address/result is
// queued when its request is driven; a negedge monitor checks the address
// phase against the queue head and pops it on the done pulse.
// -----------------------------------------------------------------------------
module tb_shared_bus_controller;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int SLAT = 2;
    localparam int SLIM = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*8-1:0]    req_op;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [1:0]           result;
    logic                 bus_valid;
    logic [7:0]           bus_op;
    logic [AW-1:0]        bus_addr;
    logic [1:0]           snoop_in;
    logic                 hitm_wb;
    logic                 mem_rdy;
    logic                 timeout_err;

    shared_bus_controller #(
        .NUM_REQ     (NREQ),
        .ADDR_W      (AW),
        .SNOOP_LAT   (SLAT),
        .STALL_LIMIT (SLIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .gnt_o         (gnt),
        .done_o        (done),
        .result_o      (result),
        .bus_valid_o   (bus_valid),
        .bus_op_o      (bus_op),
        .bus_addr_o    (bus_addr),
        .snoop_in_i    (snoop_in),
        .hitm_wb_o     (hitm_wb),
        .mem_rdy_i     (mem_rdy),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  op;
        logic [AW-1:0] addr;
        logic [1:0]  res;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   bv_cnt  = 0;
    int   cyc_now = 0;

    always @(posedge clk) cyc_now++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [AW-1:0] addr);
        req_op[8*i +: 8]     = op;
        req_addr[AW*i +: AW] = addr;
    endtask

    task automatic push_exp(input int i, input logic [1:0] res);
        exp_t e;
        e.idx  = i;
        e.op   = req_op[8*i +: 8];
        e.addr = req_addr[AW*i +: AW];
        e.res  = res;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles until done appears; an expired bound shows as a wrong count.
    task automatic wait_done(input string tag, input int exp_cyc, input int limit);
        int c;
        c = 0;
        while (done == '0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        check_eq(tag, 64'(c), 64'(exp_cyc));
    endtask

    // Monitor: address phase against queue head, done pops the head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_valid) begin
                bv_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", 64'(gnt), 64'd0);
                end else begin
                    check_eq("addr_gnt",  64'(gnt),      64'(1 << exp_q[0].idx));
                    check_eq("addr_op",   64'(bus_op),   64'(exp_q[0].op));
                    check_eq("addr_addr", 64'(bus_addr), 64'(exp_q[0].addr));
                end
            end
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("done_vec",    64'(done),     64'(1 << mon_e.idx));
                    check_eq("done_result", 64'(result),   64'(mon_e.res));
                    check_eq("done_gnt",    64'(gnt),      64'(1 << mon_e.idx));
                    check_eq("done_op",     64'(bus_op),   64'(mon_e.op));
                    check_eq("done_addr",   64'(bus_addr), 64'(mon_e.addr));
                    check_eq("bv_cycles",   64'(bv_cnt),   64'd1);
                end
                bv_cnt = 0;
            end
        end else begin
            bv_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int wb;
        int ng;
        int last;
        int bv_seen;

        rst_n    = 1'b0;
        req      = '0;
        req_op   = '0;
        req_addr = '0;
        snoop_in = 2'b00;
        mem_rdy  = 1'b0;
        step(2);
        check_eq("reset_outputs", 64'({gnt, done, result, bus_valid, bus_op, bus_addr, hitm_wb, timeout_err}), 64'd0);
        rst_n = 1'b1;
        step(1);
        check_eq("idle_gnt", 64'(gnt), 64'd0);

        // Single request, minimum latency.
        set_req(2, 8'h02, 32'h0000_1000);
        req = 4'b0100; snoop_in = 2'b00; mem_rdy = 1'b1;
        push_exp(2, 2'b00);
        step(1);
        check_eq("t1_gnt", 64'(gnt), 64'h4);
        check_eq("t1_bv_t1", 64'(bus_valid), 64'd1);
        req = '0;
        step(1);
        check_eq("t1_bv_t2", 64'(bus_valid), 64'd0);
        wait_done("t1_latency", 3, 50);
        step(1);
        check_eq("t1_idle_bus", 64'({gnt, bus_op, bus_addr}), 64'd0);

        // HITM with mem_rdy low for three writeback cycles.
        set_req(1, 8'h11, 32'h0000_2000);
        req = 4'b0010; snoop_in = 2'b10; mem_rdy = 1'b0;
        push_exp(1, 2'b10);
        step(1);
        req = '0;
        wb = 0; c = 0;
        while (done == '0 && c < 50) begin
            if (hitm_wb) begin
                wb++;
                if (wb == 4) mem_rdy = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        check_eq("t2_hitm_cycles", 64'(wb), 64'd4);
        check_eq("t2_done_seen", 64'(c < 50), 64'd1);
        step(1);

        // Five stall samples, then HIT.
        set_req(0, 8'h22, 32'h0000_3000);
        req = 4'b0001; snoop_in = 2'b11; mem_rdy = 1'b1;
        push_exp(0, 2'b01);
        step(1);
        req = '0;
        step(7);
        check_eq("t3_still_snoop", 64'({done, hitm_wb}), 64'd0);
        check_eq("t3_op_held", 64'(bus_op), 64'h22);
        snoop_in = 2'b01;
        wait_done("t3_latency", 2, 50);
        snoop_in = 2'b00;
        step(1);

        // Request dropped during SNOOP: completes, no regrant.
        set_req(3, 8'h33, 32'h0000_4000);
        req = 4'b1000;
        push_exp(3, 2'b00);
        step(2);
        req = '0;
        wait_done("t4_latency", 3, 50);
        bv_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_valid) bv_seen++;
        end
        check_eq("t4_no_regrant", 64'(bv_seen), 64'd0);

        // Asynchronous reset in the middle of writeback.
        set_req(1, 8'h44, 32'h0000_5000);
        req = 4'b0010; snoop_in = 2'b10; mem_rdy = 1'b0;
        push_exp(1, 2'b10);
        step(1);
        req = '0;
        c = 0;
        while (!hitm_wb && c < 50) begin
            @(negedge clk);
            c++;
        end
        check_eq("t5_in_wb", 64'(hitm_wb), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_clear", 64'({gnt, done, result, bus_valid, bus_op, bus_addr, hitm_wb, timeout_err}), 64'd0);
        exp_q.delete();
        @(negedge clk);

        // Fairness after reset: 0,1,2,3,0 at minimum spacing.
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h50 + 8'(i), 32'h6000 + 32'(16 * i));
        req = 4'b1111; snoop_in = 2'b00; mem_rdy = 1'b1;
        push_exp(0, 2'b00); push_exp(1, 2'b00); push_exp(2, 2'b00);
        push_exp(3, 2'b00); push_exp(0, 2'b00);
        ng = 0; last = -1; c = 0;
        while ((ng < 5 || exp_q.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
            if (bus_valid) begin
                if (last >= 0) check_eq("t6_spacing", 64'(cyc_now - last), 64'(SLAT + 4));
                last = cyc_now;
                ng++;
                if (ng == 5) req = '0;
            end
        end
        check_eq("t6_grants", 64'(ng), 64'd5);
        check_eq("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        step(1);

`ifdef SHARED_BUS_SNOOP_TIMEOUT_EN
        // Stuck stall aborts after STALL_LIMIT samples.
        set_req(2, 8'h77, 32'h0000_7000);
        req = 4'b0100; snoop_in = 2'b11; mem_rdy = 1'b1;
        push_exp(2, 2'b00);
        step(1);
        req = '0;
        wait_done("t7_timeout_latency", SLIM + 2, 100);
        snoop_in = 2'b00;
        step(2);
        check_eq("t7_timeout_sticky", 64'(timeout_err), 64'd1);
`else
        check_eq("t7_timeout_tied", 64'(timeout_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
